pf1: RTL and testbench

- Fetch-stage pipeline register (IF/ID boundary) for the 32-bit datapath.
- Latches the PC+4 value from the fetch adder (out_four) and the fetched instruction word on every rising edge of clkpf1, and presents them to the decode stage.
- Supports stall (hold), flush (insert bubble) and flags misaligned PC+4 values.

---
 rtl/pf1.sv | 62 ++++++
 tb/tb_pf1.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/pf1.sv
// pf1: IF/ID pipeline register capturing PC+4 and the fetched instruction, with stall, flush and misalign flag.
// Optional build macro PF1_LOAD_COUNT_EN adds a 32-bit load_cnt_q counter of load edges.
module pf1 #(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] NOP_WORD = '0
) (
    input  logic             clkpf1,
    input  logic             rst,
    input  logic [WIDTH-1:0] out_four,
    input  logic [WIDTH-1:0] instr_in,
    input  logic             stall,
    input  logic             flush,
    output logic [WIDTH-1:0] pc4_q,
    output logic [WIDTH-1:0] pc_q,
    output logic [WIDTH-1:0] instr_q,
    output logic             valid_q,
    output logic             misalign_q
`ifdef PF1_LOAD_COUNT_EN
    ,
    output logic [31:0]      load_cnt_q
`endif
);

    // Flush wins over stall; a load happens only when neither is asserted.
    logic load_en;
    assign load_en = !flush && !stall;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clkpf1 or posedge rst) begin
        if (rst) begin
            pc4_q      <= '0;
            instr_q    <= NOP_WORD;
            valid_q    <= 1'b0;
            misalign_q <= 1'b0;
        end else if (flush) begin
            pc4_q      <= '0;
            instr_q    <= NOP_WORD;
            valid_q    <= 1'b0;
            misalign_q <= 1'b0;
        end else if (load_en) begin
            // NOTE: the missing final else is a clock-enable hold on a flop, not a latch.
            pc4_q      <= out_four;
            instr_q    <= instr_in;
            valid_q    <= 1'b1;
            misalign_q <= (out_four[1:0] != 2'b00);
        end
    end

    // PC is recovered from PC+4 and wraps at zero.
    assign pc_q = pc4_q - WIDTH'(4);

`ifdef PF1_LOAD_COUNT_EN
    always_ff @(posedge clkpf1 or posedge rst) begin
        if (rst) begin
            load_cnt_q <= '0;
        end else if (load_en) begin
            load_cnt_q <= load_cnt_q + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pf1.sv
// tb_pf1: directed self-checking bench for the pf1 IF/ID pipeline register.
// Exercises the PF1_LOAD_COUNT_EN counter when that macro is defined.
module tb_pf1;

    localparam int W = 32;

    logic          clkpf1 = 1'b0;
    logic          rst;
    logic [W-1:0]  out_four;
    logic [W-1:0]  instr_in;
    logic          stall;
    logic          flush;
    logic [W-1:0]  pc4_q;
    logic [W-1:0]  pc_q;
    logic [W-1:0]  instr_q;
    logic          valid_q;
    logic          misalign_q;
`ifdef PF1_LOAD_COUNT_EN
    logic [31:0]   load_cnt_q;
`endif

    int errors = 0;
    int checks = 0;

    pf1 #(.WIDTH(W), .NOP_WORD(32'h0000_0000)) dut (
        .clkpf1     (clkpf1),
        .rst        (rst),
        .out_four   (out_four),
        .instr_in   (instr_in),
        .stall      (stall),
        .flush      (flush),
        .pc4_q      (pc4_q),
        .pc_q       (pc_q),
        .instr_q    (instr_q),
        .valid_q    (valid_q),
        .misalign_q (misalign_q)
`ifdef PF1_LOAD_COUNT_EN
        ,
        .load_cnt_q (load_cnt_q)
`endif
    );

    always #5 clkpf1 = ~clkpf1;

    // Advance past the next rising edge and settle 1 ns after it.
    task automatic tick();
        @(posedge clkpf1);
        #1;
    endtask

    task automatic check_slot(input string name, input logic [W-1:0] e_pc4, input logic [W-1:0] e_pc,
                              input logic [W-1:0] e_instr, input logic e_valid, input logic e_mis);
        checks++;
        if ({pc4_q, pc_q, instr_q, valid_q, misalign_q} !== {e_pc4, e_pc, e_instr, e_valid, e_mis}) begin
            errors++;
            $display("FAIL %s: got pc4=%h pc=%h instr=%h valid=%b mis=%b, expected pc4=%h pc=%h instr=%h valid=%b mis=%b",
                     name, pc4_q, pc_q, instr_q, valid_q, misalign_q, e_pc4, e_pc, e_instr, e_valid, e_mis);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        out_four = 32'h0000_0010; instr_in = 32'hDEAD_BEEF;
        #1;
        check_slot("reset_initial", 32'h0, 32'hFFFF_FFFC, 32'h0, 1'b0, 1'b0);
        tick(); tick();
        check_slot("reset_held_over_edges", 32'h0, 32'hFFFF_FFFC, 32'h0, 1'b0, 1'b0);
        // Deassert mid-cycle; the first capture happens on the following edge.
        @(negedge clkpf1);
        #2 rst = 1'b0;
        #1;
        check_slot("reset_release_no_capture", 32'h0, 32'hFFFF_FFFC, 32'h0, 1'b0, 1'b0);
        tick();
        check_slot("first_capture", 32'h0000_0010, 32'h0000_000C, 32'hDEAD_BEEF, 1'b1, 1'b0);
        // Assert reset mid-cycle: outputs clear with no clock edge.
        @(negedge clkpf1);
        #2 rst = 1'b1;
        #1;
        check_slot("async_reset_mid_cycle", 32'h0, 32'hFFFF_FFFC, 32'h0, 1'b0, 1'b0);
        @(negedge clkpf1);
        rst = 1'b0;
    endtask

    task automatic test_constant_load();
        out_four = 32'h0000_0005; instr_in = 32'h1234_5678;
        for (int i = 0; i < 6; i++) begin
            tick();
            check_slot($sformatf("const_load_cycle%0d", i), 32'h5, 32'h1, 32'h1234_5678, 1'b1, 1'b1);
        end
    endtask

    task automatic test_aligned_load();
        out_four = 32'h0000_0008; instr_in = 32'h2002_0004;
        tick();
        check_slot("aligned_load", 32'h8, 32'h4, 32'h2002_0004, 1'b1, 1'b0);
        out_four = 32'h0000_0000; instr_in = 32'h0000_0013;
        tick();
        check_slot("load_pc4_zero_wrap", 32'h0, 32'hFFFF_FFFC, 32'h0000_0013, 1'b1, 1'b0);
        out_four = 32'hFFFF_FFFE; instr_in = 32'hA5A5_5A5A;
        tick();
        check_slot("load_misalign_high", 32'hFFFF_FFFE, 32'hFFFF_FFFA, 32'hA5A5_5A5A, 1'b1, 1'b1);
    endtask

    task automatic test_stall();
        out_four = 32'h0000_0008; instr_in = 32'h2002_0004;
        tick();
        stall = 1'b1; out_four = 32'h0000_000C; instr_in = 32'h1111_2222;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_slot($sformatf("stall_hold%0d", i), 32'h8, 32'h4, 32'h2002_0004, 1'b1, 1'b0);
        end
        stall = 1'b0;
        tick();
        check_slot("stall_release", 32'hC, 32'h8, 32'h1111_2222, 1'b1, 1'b0);
    endtask

    task automatic test_flush_priority();
        out_four = 32'h0000_0008; instr_in = 32'h2002_0004;
        tick();
        check_slot("pre_flush_load", 32'h8, 32'h4, 32'h2002_0004, 1'b1, 1'b0);
        stall = 1'b1; flush = 1'b1; out_four = 32'h0000_0031; instr_in = 32'h3333_4444;
        tick();
        check_slot("flush_over_stall", 32'h0, 32'hFFFF_FFFC, 32'h0, 1'b0, 1'b0);
        stall = 1'b0;
        tick();
        check_slot("flush_alone", 32'h0, 32'hFFFF_FFFC, 32'h0, 1'b0, 1'b0);
        flush = 1'b0;
        tick();
        check_slot("load_after_flush", 32'h31, 32'h2D, 32'h3333_4444, 1'b1, 1'b1);
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] pcs [4];
        logic [W-1:0] ins [4];
        pcs = '{32'h0000_1004, 32'h0000_1008, 32'h0000_100F, 32'h8000_0000};
        ins = '{32'h0000_0001, 32'h0000_0002, 32'h0000_0003, 32'h0000_0004};
        for (int i = 0; i < 4; i++) begin
            out_four = pcs[i]; instr_in = ins[i];
            tick();
            check_slot($sformatf("b2b_%0d", i), pcs[i], pcs[i] - 32'd4, ins[i], 1'b1, pcs[i][1:0] != 2'b00);
        end
    endtask

`ifdef PF1_LOAD_COUNT_EN
    task automatic test_load_count();
        @(negedge clkpf1);
        rst = 1'b1;
        #1;
        checks++;
        if (load_cnt_q !== 32'd0) begin
            errors++;
            $display("FAIL load_cnt_reset: got %0d expected 0", load_cnt_q);
        end
        @(negedge clkpf1);
        rst = 1'b0; stall = 1'b0; flush = 1'b0; out_four = 32'h4;
        tick(); tick(); tick();
        stall = 1'b1; tick();
        stall = 1'b0; flush = 1'b1; tick();
        flush = 1'b0; tick(); tick();
        checks++;
        if (load_cnt_q !== 32'd5) begin
            errors++;
            $display("FAIL load_cnt_sequence: got %0d expected 5", load_cnt_q);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (load_cnt_q !== 32'd0) begin
            errors++;
            $display("FAIL load_cnt_rst_clear: got %0d expected 0", load_cnt_q);
        end
        rst = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_constant_load();
        test_aligned_load();
        test_stall();
        test_flush_priority();
        test_back_to_back();
`ifdef PF1_LOAD_COUNT_EN
        test_load_count();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
